// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_sequencer
// Description : Multi-channel DAC threshold scan engine with a result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer #(
    parameter int         N_CH       = 10,
    parameter int         DAC_W      = 16,
    parameter int         CNT_W      = 32,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] BASE_ADDR  = 8'h40
) (
    input  logic             clock50Mhz,
    input  logic             key_restart,
    input  logic [7:0]       addr,
    input  logic [7:0]       data,
    input  logic             write,
    input  logic [31:0]      data32,
    input  logic             write32,
    output logic [7:0]       data_out,
    input  logic             rd_pop,
    output logic [CNT_W-1:0] rdata32,
    output logic             rd_valid,
    output logic [DAC_W-1:0] dac_code,
    output logic             dac_start,
    input  logic             dac_done,
    input  logic             count,
    output logic [N_CH-1:0]  ch_sel,
    output logic             busy,
    output logic             done
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_DAC = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_GATE    = 3'd3,
        ST_STORE   = 3'd4
    } state_t;

    // Returns {found, index} of the lowest set bit of m at or above lo.
    function automatic logic [CH_W:0] find_from(input logic [N_CH-1:0] m,
                                                input logic [CH_W:0]   lo);
        logic [CH_W:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && (i >= int'(lo))) begin
                r = {1'b1, CH_W'(i)};
            end
        end
        return r;
    endfunction

    logic [7:0] offset;
    logic       in_win;
    logic       ctrl_wr;
    logic       start_cmd;
    logic       abort_cmd;
    logic       flush_cmd;
    logic       unused_bits;

    assign offset      = addr - BASE_ADDR;
    assign in_win      = (offset < 8'd8);
    assign ctrl_wr     = write && (addr == BASE_ADDR);
    assign start_cmd   = ctrl_wr && data[0];
    assign abort_cmd   = ctrl_wr && data[1];
    assign flush_cmd   = ctrl_wr && data[2];
    assign unused_bits = ^{data[7:3], data32};

    logic [N_CH-1:0]  cfg_mask_q;
    logic [DAC_W-1:0] cfg_start_q;
    logic [DAC_W-1:0] cfg_step_q;
    logic [31:0]      cfg_nsteps_q;
    logic [31:0]      cfg_settle_q;
    logic [31:0]      cfg_window_q;

    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            cfg_mask_q   <= '0;
            cfg_start_q  <= '0;
            cfg_step_q   <= '0;
            cfg_nsteps_q <= '0;
            cfg_settle_q <= '0;
            cfg_window_q <= '0;
        end else if (write32 && in_win) begin
            case (offset[2:0])
                3'd1:    cfg_mask_q   <= data32[N_CH-1:0];
                3'd2:    cfg_start_q  <= data32[DAC_W-1:0];
                3'd3:    cfg_step_q   <= data32[DAC_W-1:0];
                3'd4:    cfg_nsteps_q <= data32;
                3'd5:    cfg_settle_q <= data32;
                3'd6:    cfg_window_q <= data32;
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser followed by a registered rising-edge pulse.
    logic [2:0] sync_q;
    logic       edge_q;

    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], count};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    state_t           state_q,     state_d;
    logic [CH_W-1:0]  ch_q,        ch_d;
    logic [31:0]      step_q,      step_d;
    logic [DAC_W-1:0] code_q,      code_d;
    logic [31:0]      timer_q,     timer_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [N_CH-1:0]  sh_mask_q,   sh_mask_d;
    logic [DAC_W-1:0] sh_step_q,   sh_step_d;
    logic [31:0]      sh_nsteps_q, sh_nsteps_d;
    logic [31:0]      sh_settle_q, sh_settle_d;
    logic [31:0]      sh_window_q, sh_window_d;
    logic             dac_start_q, dac_start_d;
    logic             done_q,      done_d;

    logic             push_req;
    logic             can_push;
    logic             fifo_full;
    logic [CH_W:0]    nxt_ch;
    logic [CH_W:0]    first_cfg;
    logic [CH_W:0]    first_sh;
    logic [31:0]      gate_load;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        step_d      = step_q;
        code_d      = code_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        sh_mask_d   = sh_mask_q;
        sh_step_d   = sh_step_q;
        sh_nsteps_d = sh_nsteps_q;
        sh_settle_d = sh_settle_q;
        sh_window_d = sh_window_q;
        dac_start_d = 1'b0;
        done_d      = 1'b0;
        push_req    = 1'b0;
        nxt_ch      = find_from(sh_mask_q, {1'b0, ch_q} + 1'b1);
        first_cfg   = find_from(cfg_mask_q, '0);
        first_sh    = find_from(sh_mask_q, '0);
        gate_load   = (sh_window_q == 32'd0) ? 32'd0 : sh_window_q - 32'd1;

        if (abort_cmd) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_cmd) begin
                        sh_mask_d   = cfg_mask_q;
                        sh_step_d   = cfg_step_q;
                        sh_nsteps_d = cfg_nsteps_q;
                        sh_settle_d = cfg_settle_q;
                        sh_window_d = cfg_window_q;
                        step_d      = '0;
                        code_d      = cfg_start_q;
                        ch_d        = first_cfg[CH_W-1:0];
                        if ((cfg_mask_q == '0) || (cfg_nsteps_q == 32'd0)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d     = ST_SET_DAC;
                            dac_start_d = 1'b1;
                        end
                    end
                end
                ST_SET_DAC: begin
                    if (dac_done) begin
                        if (sh_settle_q == 32'd0) begin
                            state_d = ST_GATE;
                            timer_d = gate_load;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_SETTLE;
                            timer_d = sh_settle_q - 32'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (timer_q == 32'd0) begin
                        state_d = ST_GATE;
                        timer_d = gate_load;
                        cnt_d   = '0;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                ST_GATE: begin
                    if (edge_q && (cnt_q != '1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (timer_q == 32'd0) begin
                        state_d = ST_STORE;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                ST_STORE: begin
                    push_req = 1'b1;
                    if (can_push) begin
                        if (nxt_ch[CH_W]) begin
                            ch_d    = nxt_ch[CH_W-1:0];
                            state_d = ST_GATE;
                            timer_d = gate_load;
                            cnt_d   = '0;
                        end else if (step_q == sh_nsteps_q - 32'd1) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            step_d      = step_q + 32'd1;
                            code_d      = code_q + sh_step_q;
                            ch_d        = first_sh[CH_W-1:0];
                            state_d     = ST_SET_DAC;
                            dac_start_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            step_q      <= '0;
            code_q      <= '0;
            timer_q     <= '0;
            cnt_q       <= '0;
            sh_mask_q   <= '0;
            sh_step_q   <= '0;
            sh_nsteps_q <= '0;
            sh_settle_q <= '0;
            sh_window_q <= '0;
            dac_start_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            step_q      <= step_d;
            code_q      <= code_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            sh_mask_q   <= sh_mask_d;
            sh_step_q   <= sh_step_d;
            sh_nsteps_q <= sh_nsteps_d;
            sh_settle_q <= sh_settle_d;
            sh_window_q <= sh_window_d;
            dac_start_q <= dac_start_d;
            done_q      <= done_d;
        end
    end

    // Result FIFO; pointers carry one extra bit to tell full from empty.
    logic [CNT_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [AW:0]      occ;
    logic             push_ok;
    logic             pop_ok;
    logic [31:0]      occ32;
    logic [7:0]       occ_sat;

    assign occ       = wr_q - rd_q;
    assign fifo_full = (occ == (AW + 1)'(FIFO_DEPTH));
    assign rd_valid  = (occ != '0);
    assign can_push  = !fifo_full || rd_pop;
    assign push_ok   = push_req && can_push && !flush_cmd;
    assign pop_ok    = rd_pop && rd_valid && !flush_cmd;
    assign rdata32   = rd_valid ? mem[rd_q[AW-1:0]] : '0;
    assign occ32     = 32'(occ);
    assign occ_sat   = (occ32 > 32'd255) ? 8'hFF : occ32[7:0];

    always_ff @(posedge clock50Mhz or negedge key_restart) begin
        if (!key_restart) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush_cmd) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clock50Mhz) begin
        if (push_ok) mem[wr_q[AW-1:0]] <= cnt_q;
    end

    always_comb begin
        data_out = 8'h00;
        if (in_win) begin
            case (offset[2:0])
                3'd0:    data_out = {5'b0, fifo_full, !rd_valid, busy};
                3'd7:    data_out = occ_sat;
                default: data_out = 8'h00;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign dac_start = dac_start_q;
    assign dac_code  = code_q;
    assign ch_sel    = (state_q == ST_GATE) ? (N_CH'(1) << ch_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_sequencer
// Description : Scoreboard bench for scan_sequencer with a scan-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_sequencer;

    localparam int         N_CH       = 10;
    localparam int         DAC_W      = 16;
    localparam int         CNT_W      = 8;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [7:0] BASE       = 8'h40;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       addr = BASE;
    logic [7:0]       data = 8'h00;
    logic             write = 1'b0;
    logic [31:0]      data32 = 32'h0;
    logic             write32 = 1'b0;
    logic [7:0]       data_out;
    logic             rd_pop;
    logic [CNT_W-1:0] rdata32;
    logic             rd_valid;
    logic [DAC_W-1:0] dac_code;
    logic             dac_start;
    logic             dac_done;
    logic             count;
    logic [N_CH-1:0]  ch_sel;
    logic             busy;
    logic             done;

    scan_sequencer #(
        .N_CH      (N_CH),
        .DAC_W     (DAC_W),
        .CNT_W     (CNT_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clock50Mhz (clk),
        .key_restart(rst_n),
        .addr       (addr),
        .data       (data),
        .write      (write),
        .data32     (data32),
        .write32    (write32),
        .data_out   (data_out),
        .rd_pop     (rd_pop),
        .rdata32    (rdata32),
        .rd_valid   (rd_valid),
        .dac_code   (dac_code),
        .dac_start  (dac_start),
        .dac_done   (dac_done),
        .count      (count),
        .ch_sel     (ch_sel),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int len;
        int gap;
    } gate_t;

    logic [15:0] exp_code[$];
    gate_t       exp_gate[$];
    int          exp_res[$];

    int n_vec = 0;
    int n_err = 0;
    int exp_done = 0;
    int done_cnt = 0;
    bit pop_en = 1'b0;
    int gen_period = 0;
    int dac_dly = 3;
    int done_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // A W-cycle window over a period-P pulse train holds W/P edges when P divides W.
    function automatic int exp_count(input int window, input int period);
        int c;
        if (period == 0) return 0;
        c = window / period;
        return (c > 255) ? 255 : c;
    endfunction

    initial begin
        count = 1'b0;
        forever begin
            if (gen_period == 0) begin
                count = 1'b0;
                @(negedge clk);
            end else begin
                count = 1'b1;
                @(negedge clk);
                count = 1'b0;
                repeat (gen_period - 1) @(negedge clk);
            end
        end
    end

    initial begin
        dac_done = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_start === 1'b1) begin
                if (exp_code.size() == 0) chk("dac_start unexpected", 64'(dac_start), 0);
                else chk("dac_code", 64'(dac_code), 64'(exp_code.pop_front()));
                repeat (dac_dly) @(negedge clk);
                dac_done = 1'b1;
                done_cyc = cyc;
                @(negedge clk);
                dac_done = 1'b0;
            end
        end
    end

    initial begin
        int    run;
        gate_t g;
        run = 0;
        g.ch = -1; g.len = -1; g.gap = -1;
        forever begin
            @(negedge clk);
            if (ch_sel != '0) begin
                if (run == 0) begin
                    if (exp_gate.size() == 0) begin
                        chk("ch_sel unexpected", 64'(ch_sel), 0);
                        g.ch = -1; g.len = -1; g.gap = -1;
                    end else begin
                        g = exp_gate.pop_front();
                        chk("ch_sel", 64'(ch_sel), 64'(1) << g.ch);
                        if (g.gap >= 0) chk("settle gap", 64'(cyc - done_cyc), 64'(g.gap));
                    end
                end
                run++;
            end else if (run > 0) begin
                if (g.len >= 0) chk("gate len", 64'(run), 64'(g.len));
                run = 0;
            end
        end
    end

    initial begin
        rd_pop = 1'b0;
        forever begin
            @(negedge clk);
            rd_pop = 1'b0;
            if (pop_en && rd_valid === 1'b1) begin
                if (exp_res.size() == 0) chk("result unexpected", 64'(rd_valid), 0);
                else chk("result", 64'(rdata32), 64'(exp_res.pop_front()));
                rd_pop = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
    end

    task automatic wr8(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; data = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic wr32(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; data32 = d; write32 = 1'b1;
        @(negedge clk);
        write32 = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] v);
        @(negedge clk);
        addr = a;
        #1 v = data_out;
    endtask

    task automatic cfg(input int mask, input int start, input int step,
                       input int n, input int settle, input int window);
        wr32(BASE + 8'd1, mask);
        wr32(BASE + 8'd2, start);
        wr32(BASE + 8'd3, step);
        wr32(BASE + 8'd4, n);
        wr32(BASE + 8'd5, settle);
        wr32(BASE + 8'd6, window);
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while (done_cnt < exp_done && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("scan done count", 64'(done_cnt), 64'(exp_done));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_res.size() > 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("results drained", 64'(exp_res.size()), 0);
    endtask

    task automatic run_scan(input int mask, input int start, input int step, input int n,
                            input int settle, input int window, input int period,
                            input int dly, input bit disturb, input bit wait_end);
        gate_t       g;
        logic [15:0] code;
        int          first;
        int          nch;
        nch = 0;
        gen_period = period;
        dac_dly    = dly;
        repeat (8) @(negedge clk);
        cfg(mask, start, step, n, settle, window);
        if (mask != 0 && n != 0) begin
            for (int s = 0; s < n; s++) begin
                code = 16'(start + s * step);
                exp_code.push_back(code);
                first = 1;
                for (int c = 0; c < N_CH; c++) begin
                    if (mask[c]) begin
                        g.ch  = c;
                        g.len = (window == 0) ? 1 : window;
                        g.gap = first ? settle + 1 : -1;
                        first = 0;
                        exp_gate.push_back(g);
                        exp_res.push_back(exp_count(window, period));
                        nch++;
                    end
                end
            end
        end
        exp_done++;
        wr8(BASE, 8'h01);
        #1;
        if (mask == 0 || n == 0) begin
            chk("empty scan done", 64'(done), 1);
            chk("empty scan busy", 64'(busy), 0);
        end else begin
            chk("busy rise", 64'(busy), 1);
        end
        if (disturb) begin
            repeat (20) @(negedge clk);
            cfg(10'h3FF, 0, 0, 5, 0, 7);
            wr8(BASE, 8'h01);
        end
        if (wait_end) begin
            wait_done(n * (dly + settle + 10) + nch * (window + 3) + 200);
            if (pop_en) drain();
            @(negedge clk);
            #1 chk("busy end", 64'(busy), 0);
        end
    endtask

    initial begin
        logic [7:0] v;
        int         t;
        int         p;

        repeat (3) @(negedge clk);
        #1;
        chk("reset status", 64'(data_out), 8'h02);
        chk("reset rd_valid", 64'(rd_valid), 0);
        chk("reset rdata32", 64'(rdata32), 0);
        chk("reset dac_code", 64'(dac_code), 0);
        chk("reset dac_start", 64'(dac_start), 0);
        chk("reset ch_sel", 64'(ch_sel), 0);
        chk("reset busy", 64'(busy), 0);
        chk("reset done", 64'(done), 0);
        rst_n = 1'b1;
        rd(BASE + 8'd7, v);
        chk("reset occupancy", 64'(v), 0);
        rd(BASE + 8'd3, v);
        chk("readback unmapped", 64'(v), 0);
        rd(8'h10, v);
        chk("readback outside", 64'(v), 0);
        pop_en = 1'b1;

        run_scan(10'b101, 100, 10, 3, 4, 50, 5, 3, 1'b1, 1'b1);
        run_scan(10'b1, 16'hFFF0, 16'h0010, 2, 1, 5, 5, 2, 1'b0, 1'b1);
        run_scan(10'b10_0000_0001, 16'hA000, 16'h0100, 2, 0, 0, 0, 0, 1'b0, 1'b1);
        run_scan(10'b1, 0, 0, 1, 0, 600, 2, 1, 1'b0, 1'b1);

        pop_en = 1'b0;
        run_scan(10'b11, 5, 1, 4, 1, 10, 2, 2, 1'b0, 1'b0);
        t = 0;
        v = 8'h00;
        while (v[2] !== 1'b1 && t < 2000) begin
            rd(BASE, v);
            t++;
        end
        chk("stall status", 64'(v), 8'h05);
        repeat (40) @(negedge clk);
        rd(BASE, v);
        chk("still stalled", 64'(v), 8'h05);
        rd(BASE + 8'd7, v);
        chk("occupancy full", 64'(v), FIFO_DEPTH);
        pop_en = 1'b1;
        wait_done(2000);
        drain();

        pop_en = 1'b0;
        gen_period = 4;
        dac_dly    = 1;
        repeat (8) @(negedge clk);
        cfg(10'b11, 16'h1234, 0, 1, 2, 40);
        begin
            gate_t g;
            exp_code.push_back(16'h1234);
            g.ch = 0; g.len = 40; g.gap = 3;
            exp_gate.push_back(g);
            g.ch = 1; g.len = -1; g.gap = -1;
            exp_gate.push_back(g);
            exp_res.push_back(10);
        end
        exp_done++;
        wr8(BASE, 8'h01);
        t = 0;
        while (ch_sel !== 10'b10 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("second gate reached", 64'(ch_sel), 10'b10);
        repeat (5) @(negedge clk);
        rd(BASE + 8'd7, v);
        chk("occupancy before abort", 64'(v), 1);
        wr8(BASE, 8'h02);
        #1;
        chk("abort ch_sel", 64'(ch_sel), 0);
        chk("abort done", 64'(done), 1);
        chk("abort busy", 64'(busy), 0);
        rd(BASE + 8'd7, v);
        chk("occupancy after abort", 64'(v), 1);
        wait_done(5);
        pop_en = 1'b1;
        drain();

        pop_en = 1'b0;
        run_scan(10'b111, 0, 0, 1, 0, 4, 2, 0, 1'b0, 1'b1);
        rd(BASE + 8'd7, v);
        chk("occupancy before flush", 64'(v), 3);
        wr8(BASE, 8'h04);
        #1;
        chk("flush rd_valid", 64'(rd_valid), 0);
        chk("flush rdata32", 64'(rdata32), 0);
        rd(BASE + 8'd7, v);
        chk("flush occupancy", 64'(v), 0);
        rd(BASE, v);
        chk("flush status", 64'(v), 8'h02);
        exp_res.delete();
        pop_en = 1'b1;

        run_scan(10'b101, 7, 1, 0, 2, 10, 2, 1, 1'b0, 1'b1);
        run_scan(0, 7, 1, 2, 2, 10, 2, 1, 1'b0, 1'b1);
        chk("empty scans leave FIFO empty", 64'(rd_valid), 0);

        for (int it = 0; it < 8; it++) begin
            p = int'($urandom_range(2, 5));
            run_scan(int'($urandom_range(1, 1023)), int'($urandom), int'($urandom),
                     int'($urandom_range(1, 3)), int'($urandom_range(0, 5)),
                     p * int'($urandom_range(1, 6)), p, int'($urandom_range(0, 4)),
                     1'b0, 1'b1);
        end

        repeat (10) @(negedge clk);
        chk("codes left", 64'(exp_code.size()), 0);
        chk("gates left", 64'(exp_gate.size()), 0);
        chk("results left", 64'(exp_res.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_sequencer.md
# scan_sequencer

Parametrised scan engine that generalises the single-channel step/count handshake between the DAC, gate and counter blocks into an autonomous multi-channel threshold scan. For each DAC step it loads a code, waits for DAC completion and settling, then gates every enabled channel in turn for a programmed window and counts `count` pulses. Each channel's count is pushed into a result FIFO. The block sits on the shared `addr`/`data`/`write`/`write32` command bus next to pwm, counter, gate and spidac; its 8-bit readback feeds the data selector.

## Interface
- `N_CH`, 10: number of gate channels (1..32)
- `DAC_W`, 16: DAC code width
- `CNT_W`, 32: count width (≤32)
- `FIFO_DEPTH`, 16: result FIFO depth (power of two)
- `BASE_ADDR`, 8'h40: base of 8-address register window

- `clock50Mhz`  in  1  system clock; the block has one clock
- `key_restart`  in  1  reset, asynchronous, active-low
- `addr`  in  8  command address
- `data`  in  8  8-bit write data
- `write`  in  1  8-bit write strobe, one cycle
- `data32`  in  32  32-bit write data
- `write32`  in  32-bit write strobe, one cycle
- `data_out`  out  8  register readback, combinational from `addr`
- `rd_pop`  in  1  FIFO pop strobe
- `rdata32`  out  CNT_W  FIFO head (show-ahead)
- `rd_valid`  out  1  FIFO not empty
- `dac_code`  out  DAC_W  code for DAC block
- `dac_start`  out  1  one-cycle DAC load request
- `dac_done`  in  1  DAC load complete, one-cycle pulse
- `count`  in  1  asynchronous pulse input
- `ch_sel`  out  N_CH  one-hot gate enable
- `busy`  out  1  scan in progress
- `done`  out  1  one-cycle pulse at scan end or abort

## Operation
- Registers (offset from BASE_ADDR): +0 CTRL via `write`: bit0 start, bit1 abort, bit2 flush (self-clearing). +1..+6 via `write32`: channel mask [N_CH-1:0], start code [DAC_W-1:0], step [DAC_W-1:0], n_steps, settle cycles, window cycles.
- Reads: +0 = {5'b0, fifo_full, !rd_valid, busy}; +7 = FIFO occupancy (saturates at 255); other offsets return 8'h00; addresses outside window return 8'h00.
- Config writes while busy are accepted but take effect at next start (shadow copy latched on start).
- States: IDLE -> SET_DAC -> SETTLE -> GATE -> STORE -> (next channel: GATE | next step: SET_DAC | end: IDLE).
- IDLE: start with busy=0 latches config, step index s=0, channel pointer = lowest set mask bit. If mask=0 or n_steps=0: no DAC activity, `done` pulses next cycle, stay IDLE.
- SET_DAC: `dac_code` = start + s*step, modulo 2^DAC_W (wrap, no saturation); `dac_start` pulses on entry cycle only; wait for `dac_done`.
- SETTLE: wait settle cycles (0 = skip directly to GATE).
- GATE: `ch_sel` one-hot on current channel; window cycles (0 treated as 1); counter zeroed on entry, increments per synchronised rising edge of `count`, saturates at all ones.
- STORE: push count; if FIFO full and no `rd_pop` this cycle, stall in STORE (no data loss, `ch_sel`=0). Then advance to next set mask bit ascending; after last channel, s++; after s=n_steps-1, assert `done`, go IDLE.
- Abort (any state): next cycle IDLE, `ch_sel`=0, `dac_start`=0, `done` pulses; partial count discarded; FIFO kept.
- Start while busy: ignored. Start+abort same write: abort wins.
- FIFO: `rd_pop` on empty ignored; simultaneous push and pop when full allowed; flush empties FIFO, flush wins over simultaneous push/pop.

## Timing
- Reset values: `data_out` per reset registers (all config 0), `rdata32`=0, `rd_valid`=0, `dac_code`=0, `dac_start`=0, `ch_sel`=0, `busy`=0, `done`=0; FIFO empty; state IDLE.
- `count`: 2-flop synchroniser + edge detect; an edge is counted if its detected pulse falls within the GATE cycles; pipeline latency 3 cycles.
- `busy` rises the cycle after start write, falls together with `done`.
- `dac_start` cycle after start write (1-cycle latency); SETTLE begins cycle after `dac_done`.
- GATE lasts exactly window cycles; STORE is 1 cycle when not full.
- `rdata32`/`rd_valid` update cycle after push into empty FIFO; pop advances head next cycle.

## Test plan
- Mask=0b101, start=100, step=10, n_steps=3, settle=4, window=50, 1 pulse per 5 cycles, `dac_done` 3 cycles after `dac_start` -> codes 100,110,120; six FIFO entries of 10 each; `ch_sel` alternates bit0, bit2; one `done`.
- DAC_W=16, start=16'hFFF0, step=16'h0010, n_steps=2 -> codes FFF0 then 0000.
- FIFO_DEPTH=4, 8 results, no pops -> stall in STORE with fifo_full=1; pop 4 -> remaining 4 stored in order, no loss.
- Abort mid-GATE -> `ch_sel`=0 and `done` next cycle, FIFO occupancy unchanged, busy=0.
- n_steps=0 start -> `done` 1 cycle later, no `dac_start`, FIFO empty.
- CNT_W=8, window=600, pulse every 2 cycles -> stored count 8'hFF (saturated).
